// File: rtl/unroll.sv
// unroll: sequential inverse of the prefix-sum nibble roller.
// Recovers t[i] = (enc[i] - sum_{j<i} enc[j]) mod 16, one nibble per clock.
module unroll #(
    parameter int unsigned NIB = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4*NIB-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [4*NIB-1:0]   out
);

    localparam int unsigned DW = 4 * NIB;
    localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   word_q,  word_d;
    logic [DW-1:0]   out_q,   out_d;
    logic [3:0]      sum_q,   sum_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [3:0]      enc_nib;
    logic [3:0]      dec_nib;

    // Current encoded nibble and its decoded value (4-bit wraparound).
    always_comb begin
        enc_nib = word_q[{idx_q, 2'b00} +: 4];
        dec_nib = enc_nib - sum_q;
    end

    // Next-state and datapath update; busy/done registered from next state.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        out_d   = out_q;
        sum_d   = sum_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_d  = in;
                    out_d   = '0;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                out_d[{idx_q, 2'b00} +: 4] = dec_nib;
                sum_d = sum_q + enc_nib;
                if (idx_q == IW'(NIB - 1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            out_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            out_q   <= out_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_unroll.sv
// Directed and round-trip bench for unroll (NIB = 8).
module tb_unroll;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] in;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int tests = 0;
    int fails = 0;

    unroll #(.NIB(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .in    (in),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Encoder model: enc[i] = (t[i] + sum_{j<i} enc[j]) mod 16.
    function automatic logic [31:0] roll(input logic [31:0] t);
        logic [31:0] e;
        logic [3:0]  s;
        logic [3:0]  n;
        e = '0;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            n = t[4*i +: 4] + s;
            e[4*i +: 4] = n;
            s = s + n;
        end
        return e;
    endfunction

    // Accept a start, then wait (bounded) for done; checks busy span and result.
    task automatic decode(input string tag, input logic [31:0] w, input logic [31:0] exp,
                          input bit full);
        int nb;
        start = 1'b1;
        in    = w;
        tick();
        start = 1'b0;
        if (full) chk({tag, "_out_cleared"}, out, 32'h0);
        nb = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            if (busy) nb++;
            tick();
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_out"}, out, exp);
        if (full) begin
            chk({tag, "_busy_cycles"}, nb, 32'd8);
            tick();
            chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
            chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
            chk({tag, "_hold"}, out, exp);
        end else begin
            tick();
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] specials [4];
        int          ndone;

        // 1: reset held with start asserted
        reset = 1'b1;
        start = 1'b1;
        in    = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_busy", {31'b0, busy}, 32'd0);
            chk("rst_done", {31'b0, done}, 32'd0);
            chk("rst_out", out, 32'h0);
        end
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_busy", {31'b0, busy}, 32'd0);

        // 2: basic decode
        decode("t2", 32'h0008_4211, 32'h0000_0001, 1'b1);
        tick();
        chk("t2_hold_idle", out, 32'h0000_0001);

        // 3: all-ones word, also checks clearing of previous out
        decode("t3", 32'hFFFF_FFFF, 32'h6543_210F, 1'b1);

        // 4: in/start changes during RUN and DONE are ignored
        start = 1'b1;
        in    = 32'h1234_5678;
        tick();
        in    = 32'h0;
        tick();
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) break;
            tick();
        end
        chk("t4_done", {31'b0, done}, 32'd1);
        chk("t4_out", out, 32'hE15A_07F8);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_no_restart_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 12; k++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("t4_no_extra_activity", ndone, 32'd0);
        chk("t4_hold", out, 32'hE15A_07F8);
        decode("t4b", 32'h0, 32'h0, 1'b1);

        // 5: reset in the middle of RUN
        start = 1'b1;
        in    = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t5_partial", out, 32'h0000_210F);
        chk("t5_partial_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_done", {31'b0, done}, 32'd0);
        chk("t5_rst_out", out, 32'h0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) ndone++;
            tick();
        end
        chk("t5_no_done", ndone, 32'd0);
        decode("t5b", 32'h0008_4211, 32'h0000_0001, 1'b1);

        // 6: round trip through the encoder model
        specials[0] = 32'h0000_0000;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h0000_000F;
        for (int i = 0; i < 4; i++) begin
            decode("rt_special", roll(specials[i]), specials[i], 1'b1);
        end
        for (int i = 0; i < 496; i++) begin
            r = $urandom;
            decode("rt_rand", roll(r), r, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/unroll.md
Name: unroll

Overview:
- Sequential inverse of the combinational prefix-sum nibble roller `roll`.
- That encoder produces `enc[i] = (t[i] + sum_{j<i} enc[j]) mod 16`. This block recovers `t[i] = (enc[i] - sum_{j<i} enc[j]) mod 16`.
- Decodes one nibble per clock with a start/done handshake.
- Sits on the receive side of any path that carries rolled words.

Parameters:
- NIB, 8, number of 4-bit nibbles per word; data width is 4*NIB.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to decode `in`; sampled only in IDLE.
- in  input  4*NIB  rolled (encoded) word; nibble 0 = bits [3:0].
- busy  output  1  high while nibbles are being decoded (RUN state).
- done  output  1  one-cycle pulse: `out` is valid and complete.
- out  output  4*NIB  decoded word; registered; held until the next accepted start.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - While `reset`=1 at a rising edge: state=IDLE, busy=0, done=0, out=0, internal sum=0, index=0, latched word=0.
  - Reset overrides every other input, including mid-RUN. A partially decoded word is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch `in` into an internal word register, clear out to 0, sum=0, index=0, go to RUN.
  - start=0: stay in IDLE and hold out.
- RUN: at each edge, with `e` = latched nibble[index]:
  - Write out nibble[index] = (e - sum) mod 16. Use 4-bit wraparound subtraction; no borrow is kept.
  - sum = (sum + e) mod 16. The running sum of encoded nibbles equals the encoder's prefix sum mod 16.
  - index += 1. When index was NIB-1, go to DONE.
  - `in` and `start` are ignored during RUN; later changes to `in` have no effect.
- DONE:
  - done=1 for exactly this one cycle.
  - At the next edge go to IDLE unconditionally. A start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Outputs:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
  - Both are decoded from registered state, so they are glitch-free.
- Latency:
  - Start accepted at edge E0; nibbles 0..NIB-1 written at E1..E_NIB.
  - done is high in the cycle after E_NIB.
  - With NIB=8: done is high 8 cycles after the accept edge; 10-cycle minimum start-to-start spacing.
- Partial results: out is visible while in RUN, nibble by nibble. Consumers must sample only when done=1.
- Arithmetic: all nibble math is modulo 16. The sum register is 4 bits and wraps.
- Index counter: width clog2(NIB) bits; it never exceeds NIB-1.

Test Plan:
1. reset=1 for 2 cycles with start=1, in=0xFFFFFFFF -> busy=0, done=0, out=0x00000000 throughout; no RUN entry.
2. start pulse with in=0x00084211 -> busy high for 8 cycles, then done=1 for 1 cycle with out=0x00000001. Output holds after return to IDLE.
3. start with in=0xFFFFFFFF -> out=0x6543210F at done. Nibble trace (t0..t7): F,0,1,2,3,4,5,6; sum trace F,E,D,C,B,A,9,8.
4. start with in=0x12345678. Change `in` to 0 and pulse start during RUN and during DONE -> result unaffected, no restart, exactly one done pulse. Then a fresh start in IDLE decodes in=0 -> out=0x00000000.
5. Mid-RUN reset after 4 nibbles of in=0xFFFFFFFF -> next cycle IDLE, out=0, busy=0, no done. Subsequent start with in=0x00084211 -> out=0x00000001.
6. Round trip: 500 random words r; drive in=roll(r) -> out==r at every done. Include r=0x00000000, 0xFFFFFFFF, 0x80000000, 0x0000000F.
